unidad_logico_aritmetica_secuencial: RTL and testbench

UNIDAD_LOGICO_ARITMETICA_SECUENCIAL -- requirements
Module: unidad_logico_aritmetica_secuencial

---
 rtl/unidad_logico_aritmetica_secuencial.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_unidad_logico_aritmetica_secuencial.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_logico_aritmetica_secuencial.sv
// ---------------------------------------------------------------------------
// unidad_logico_aritmetica_secuencial
//
// Multi-cycle ALU with a valid/ready request handshake on the input side and
// a valid/ready result handshake on the output side. The block accepts one
// operation at a time. It captures the operands and then does one of three
// things:
//   - evaluates the operation in a single EXEC cycle (logic, add, sub,
//     zero-length shifts, reserved opcodes);
//   - walks a shift one bit per cycle in SHIFT;
//   - runs a WIDTH-step unsigned shift-add multiply in MUL, when that is
//     compiled in.
// Each operation ends in DONE, where the result and flags are held until the
// consumer takes them.
//
// Optional feature: define ALU_MULT_EN to compile in the multiplier (opcode
// 1110). Without it, 1110 behaves as a reserved opcode and no multiplier
// datapath is built.
//
// Parameters:
//   WIDTH        operand/result width (4..64)
//   SHAMT_W      shift-amount width
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     request present           in_ready   block can accept (IDLE)
//   numero1      operand A                 numero2    operand B
//   shamt        shift amount              ALUControl 4-bit opcode
//   out_valid    result/flags valid        out_ready  consumer takes result
//   resultado    result
//   flagNegativo / flagCero / flagOverflow / flagCarry   N, Z, V, C flags
//   busy         high whenever not IDLE
// ---------------------------------------------------------------------------
module unidad_logico_aritmetica_secuencial #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   numero1,
  input  logic [WIDTH-1:0]   numero2,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [3:0]         ALUControl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   resultado,
  output logic               flagNegativo,
  output logic               flagCero,
  output logic               flagOverflow,
  output logic               flagCarry,
  output logic               busy
);

  // The counter must reach WIDTH for the multiplier, which SHAMT_W cannot hold.
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_MUL   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_XOR   = 4'b0010;
  localparam logic [3:0] OP_NOT   = 4'b0011;
  localparam logic [3:0] OP_LSR_A = 4'b0100;
  localparam logic [3:0] OP_LSL_A = 4'b0101;
  localparam logic [3:0] OP_LSR_B = 4'b0110;
  localparam logic [3:0] OP_LSL_B = 4'b0111;
  localparam logic [3:0] OP_ADD   = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_ASR_A = 4'b1010;
  localparam logic [3:0] OP_ASL_A = 4'b1011;
  localparam logic [3:0] OP_ASR_B = 4'b1100;
  localparam logic [3:0] OP_ASL_B = 4'b1101;
  localparam logic [3:0] OP_MUL   = 4'b1110;
  localparam logic [3:0] OP_RSV   = 4'b1111;

  function automatic logic is_shift(input logic [3:0] op);
    case (op)
      OP_LSR_A, OP_LSL_A, OP_LSR_B, OP_LSL_B,
      OP_ASR_A, OP_ASL_A, OP_ASR_B, OP_ASL_B: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic uses_b(input logic [3:0] op);
    return (op == OP_LSR_B) || (op == OP_LSL_B) || (op == OP_ASR_B) || (op == OP_ASL_B);
  endfunction

  function automatic logic is_left(input logic [3:0] op);
    return (op == OP_LSL_A) || (op == OP_LSL_B) || (op == OP_ASL_A) || (op == OP_ASL_B);
  endfunction

  function automatic logic is_asr(input logic [3:0] op);
    return (op == OP_ASR_A) || (op == OP_ASR_B);
  endfunction

  function automatic logic is_asl(input logic [3:0] op);
    return (op == OP_ASL_A) || (op == OP_ASL_B);
  endfunction

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             shv_q, shv_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             v_q, v_d;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] exec_res;
  logic             exec_c;
  logic             exec_v;

  logic [WIDTH-1:0] step_res;
  logic             step_c;
  logic             step_chg;

`ifdef ALU_MULT_EN
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_step;

  // Right-shifting shift-add multiplier. The low half starts as the
  // multiplier, and its LSB decides whether A is added into the high half.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    prod_step = {mul_sum, prod_q[WIDTH-1:1]};
  end
`endif

  // Single-cycle evaluation. For shift opcodes this is reached only with a
  // zero shift amount, so the operand passes through unchanged with C=V=0.
  always_comb begin
    exec_res = '0;
    exec_c   = 1'b0;
    exec_v   = 1'b0;
    add_full = {1'b0, a_q} + {1'b0, b_q};
    sub_full = {1'b0, a_q} - {1'b0, b_q};
    case (op_q)
      OP_AND: exec_res = a_q & b_q;
      OP_OR:  exec_res = a_q | b_q;
      OP_XOR: exec_res = a_q ^ b_q;
      OP_NOT: exec_res = ~a_q;
      OP_ADD: begin
        exec_res = add_full[WIDTH-1:0];
        exec_c   = add_full[WIDTH];
        exec_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_full[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        // The carry is the inverted borrow, so it is 1 when A >= B unsigned.
        exec_res = sub_full[WIDTH-1:0];
        exec_c   = ~sub_full[WIDTH];
        exec_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_full[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_LSR_A, OP_LSL_A, OP_LSR_B, OP_LSL_B,
      OP_ASR_A, OP_ASL_A, OP_ASR_B, OP_ASL_B: exec_res = a_q;
      OP_MUL, OP_RSV:                          exec_res = '0;
      default:                                 exec_res = '0;
    endcase
  end

  // One-bit shift step on the working operand held in a_q. step_chg flags an
  // MSB change, which only matters for the ASL overflow.
  always_comb begin
    if (is_left(op_q)) begin
      step_res = {a_q[WIDTH-2:0], 1'b0};
      step_c   = a_q[WIDTH-1];
    end else begin
      step_res = {(is_asr(op_q) ? a_q[WIDTH-1] : 1'b0), a_q[WIDTH-1:1]};
      step_c   = a_q[0];
    end
    step_chg = is_left(op_q) && (step_res[WIDTH-1] != a_q[WIDTH-1]);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    shv_d    = shv_q;
    result_d = result_q;
    n_d      = n_q;
    z_d      = z_q;
    c_d      = c_q;
    v_d      = v_q;
`ifdef ALU_MULT_EN
    prod_d   = prod_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Shift opcodes that act on B load B into the working register so
          // that the shift datapath never has to choose an operand.
          a_d   = (is_shift(ALUControl) && uses_b(ALUControl)) ? numero2 : numero1;
          b_d   = numero2;
          op_d  = ALUControl;
          cnt_d = CNT_W'(shamt);
          shv_d = 1'b0;
          if (is_shift(ALUControl) && (shamt != '0)) begin
            state_d = S_SHIFT;
          end
`ifdef ALU_MULT_EN
          else if (ALUControl == OP_MUL) begin
            state_d = S_MUL;
            cnt_d   = CNT_W'(WIDTH);
            prod_d  = {{WIDTH{1'b0}}, numero2};
          end
`endif
          else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        result_d = exec_res;
        n_d      = exec_res[WIDTH-1];
        z_d      = (exec_res == '0);
        c_d      = exec_c;
        v_d      = exec_v;
        state_d  = S_DONE;
      end
      S_SHIFT: begin
        a_d   = step_res;
        shv_d = shv_q | step_chg;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = step_res;
          n_d      = step_res[WIDTH-1];
          z_d      = (step_res == '0);
          c_d      = step_c;
          v_d      = is_asl(op_q) ? (shv_q | step_chg) : 1'b0;
          state_d  = S_DONE;
        end
      end
      S_MUL: begin
`ifdef ALU_MULT_EN
        prod_d = prod_step;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = prod_step[WIDTH-1:0];
          n_d      = prod_step[WIDTH-1];
          z_d      = (prod_step[WIDTH-1:0] == '0);
          c_d      = |prod_step[2*WIDTH-1:WIDTH];
          v_d      = 1'b0;
          state_d  = S_DONE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      shv_q    <= 1'b0;
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
`ifdef ALU_MULT_EN
      prod_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      shv_q    <= shv_d;
      result_q <= result_d;
      n_q      <= n_d;
      z_q      <= z_d;
      c_q      <= c_d;
      v_q      <= v_d;
`ifdef ALU_MULT_EN
      prod_q   <= prod_d;
`endif
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign resultado    = result_q;
  assign flagNegativo = n_q;
  assign flagCero     = z_q;
  assign flagCarry    = c_q;
  assign flagOverflow = v_q;

endmodule

// File: tb/tb_unidad_logico_aritmetica_secuencial.sv
// ---------------------------------------------------------------------------
// Testbench for unidad_logico_aritmetica_secuencial at WIDTH=4.
// A table of known vectors is applied first. Hand-written sequences then
// cover reset during a shift and holding a result in DONE. Random requests
// are checked last against an arithmetic reference model. Honours
// ALU_MULT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_unidad_logico_aritmetica_secuencial;

  localparam int W    = 4;
  localparam int SW   = 2;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  numero1;
  logic [W-1:0]  numero2;
  logic [SW-1:0] shamt;
  logic [3:0]    ALUControl;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  resultado;
  logic          flagNegativo;
  logic          flagCero;
  logic          flagOverflow;
  logic          flagCarry;
  logic          busy;

  int checks;
  int failures;

  typedef struct {
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] s;
    logic [W-1:0]  res;
    logic [3:0]    nzcv;
    int            lat;
  } vec_t;

  vec_t vecs[$];

  unidad_logico_aritmetica_secuencial #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .numero1      (numero1),
    .numero2      (numero2),
    .shamt        (shamt),
    .ALUControl   (ALUControl),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .resultado    (resultado),
    .flagNegativo (flagNegativo),
    .flagCero     (flagCero),
    .flagOverflow (flagOverflow),
    .flagCarry    (flagCarry),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arithmetic on the operands, returning result,
  // {N,Z,C,V} and the expected number of edges from acceptance to out_valid.
  function automatic void refModel(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input int s, output logic [W-1:0] r, output logic [3:0] nzcv,
                                   output int lat);
    logic [W-1:0] x;
    logic c;
    logic v;
    logic sh;
    int full;
    int ssum;
    c   = 1'b0;
    v   = 1'b0;
    r   = '0;
    lat = 1;
    sh  = op inside {4'h4, 4'h5, 4'h6, 4'h7, 4'ha, 4'hb, 4'hc, 4'hd};
    x   = (op inside {4'h6, 4'h7, 4'hc, 4'hd}) ? b : a;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: r = a ^ b;
      4'h3: r = ~a;
      4'h4, 4'h6: begin
        r = x >> s;
        if (s > 0) c = x[s-1];
      end
      4'ha, 4'hc: begin
        r = W'($signed(x) >>> s);
        if (s > 0) c = x[s-1];
      end
      4'h5, 4'h7, 4'hb, 4'hd: begin
        r = x << s;
        if (s > 0) c = x[W-s];
        if (op == 4'hb || op == 4'hd) begin
          for (int i = W - 1 - s; i < W; i++) if (x[i] != x[W-1]) v = 1'b1;
        end
      end
      4'h8: begin
        full = int'(a) + int'(b);
        r    = W'(full);
        c    = full >= (1 << W);
        ssum = int'($signed(a)) + int'($signed(b));
        v    = (ssum > SMAX) || (ssum < SMIN);
      end
      4'h9: begin
        full = int'(a) - int'(b);
        r    = W'(full);
        c    = a >= b;
        ssum = int'($signed(a)) - int'($signed(b));
        v    = (ssum > SMAX) || (ssum < SMIN);
      end
`ifdef ALU_MULT_EN
      4'he: begin
        full = int'(a) * int'(b);
        r    = W'(full);
        c    = full >= (1 << W);
        lat  = W;
      end
`endif
      default: r = '0;
    endcase
    if (sh && s > 0) lat = s;
    nzcv = {r[W-1], (r == '0), c, v};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Present one request at the current point (1 time unit after an edge),
  // scramble the inputs right after acceptance, and wait for out_valid.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [SW-1:0] s, output int lat);
    ALUControl = op;
    numero1    = a;
    numero2    = b;
    shamt      = s;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    ALUControl = 4'($urandom);
    numero1    = W'($urandom);
    numero2    = W'($urandom);
    shamt      = SW'($urandom);
    checkOutput("busy_after_accept", {62'd0, busy, in_ready}, 64'b10);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("ready_after_release", {62'd0, in_ready, out_valid}, 64'b10);
  endtask

  task automatic runVector(input string name, input vec_t t);
    int lat;
    applyStimulus(t.op, t.a, t.b, t.s, lat);
    checkOutput({name, "_result"},
                {56'd0, resultado, flagNegativo, flagCero, flagCarry, flagOverflow},
                {56'd0, t.res, t.nzcv});
    checkOutput({name, "_latency"}, 64'(lat), 64'(t.lat));
    releaseResult();
  endtask

  task automatic addVec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [SW-1:0] s, input logic [W-1:0] res, input logic [3:0] nzcv,
                        input int lat);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.s = s; t.res = res; t.nzcv = nzcv; t.lat = lat;
    vecs.push_back(t);
  endtask

  initial begin
    vec_t          t;
    logic [W-1:0]  r;
    logic [3:0]    nzcv;
    int            lat;

    checks     = 0;
    failures   = 0;
    rst_n      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    numero1    = '0;
    numero2    = '0;
    shamt      = '0;
    ALUControl = '0;

    // Known vectors, result and {N,Z,C,V} worked out by hand.
    addVec(4'h0, 4'b1110, 4'b1000, 2'd1, 4'b1000, 4'b1000, 1);
    addVec(4'h1, 4'b1110, 4'b1000, 2'd1, 4'b1110, 4'b1000, 1);
    addVec(4'h2, 4'b1110, 4'b1000, 2'd1, 4'b0110, 4'b0000, 1);
    addVec(4'h3, 4'b1110, 4'b1000, 2'd1, 4'b0001, 4'b0000, 1);
    addVec(4'h4, 4'b1110, 4'b1000, 2'd1, 4'b0111, 4'b0000, 1);
    addVec(4'h5, 4'b1110, 4'b1000, 2'd1, 4'b1100, 4'b1010, 1);
    addVec(4'h6, 4'b1110, 4'b1000, 2'd1, 4'b0100, 4'b0000, 1);
    addVec(4'h7, 4'b1110, 4'b1000, 2'd1, 4'b0000, 4'b0110, 1);
    addVec(4'h8, 4'b1110, 4'b1000, 2'd1, 4'b0110, 4'b0011, 1);
    addVec(4'h9, 4'b1110, 4'b1000, 2'd1, 4'b0110, 4'b0010, 1);
    addVec(4'hb, 4'b0110, 4'b0000, 2'd1, 4'b1100, 4'b1001, 1);
    addVec(4'h5, 4'b1011, 4'b0000, 2'd0, 4'b1011, 4'b1000, 1);
    addVec(4'hf, 4'b1111, 4'b1111, 2'd3, 4'b0000, 4'b0100, 1);
`ifdef ALU_MULT_EN
    addVec(4'he, 4'b0011, 4'b0101, 2'd0, 4'b1111, 4'b1000, W);
`else
    addVec(4'he, 4'b0011, 4'b0101, 2'd0, 4'b0000, 4'b0100, 1);
`endif
    addVec(4'ha, 4'b1000, 4'b0000, 2'd3, 4'b1111, 4'b1000, 3);

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_state",
                {55'd0, in_ready, out_valid, busy, resultado, flagNegativo, flagCero, flagCarry, flagOverflow},
                {55'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000});
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      runVector($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset during a 3-step shift; resultado still holds 1111 from the last vector.
    ALUControl = 4'ha;
    numero1    = 4'b0100;
    numero2    = 4'b0000;
    shamt      = 2'd3;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_reset",
                {55'd0, in_ready, out_valid, busy, resultado, flagNegativo, flagCero, flagCarry, flagOverflow},
                {55'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000});
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("idle_after_abort", {62'd0, in_ready, out_valid}, 64'b10);
    t.op = 4'h8; t.a = 4'b0011; t.b = 4'b0100; t.s = 2'd0; t.res = 4'b0111; t.nzcv = 4'b0000; t.lat = 1;
    runVector("after_abort", t);

    // Hold a result in DONE for five cycles with out_ready low.
    applyStimulus(4'h8, 4'b1110, 4'b1000, 2'd2, lat);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("hold%0d", i),
                  {56'd0, out_valid, in_ready, resultado, flagNegativo, flagCero, flagCarry, flagOverflow},
                  {56'd0, 1'b1, 1'b0, 4'b0110, 4'b0011});
      @(posedge clk);
      #1;
    end
    releaseResult();

    // Random requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      t.op = 4'($urandom);
      t.a  = W'($urandom);
      t.b  = W'($urandom);
      t.s  = SW'($urandom);
      refModel(t.op, t.a, t.b, int'(t.s), r, nzcv, lat);
      t.res  = r;
      t.nzcv = nzcv;
      t.lat  = lat;
      runVector($sformatf("rand%0d_op%0h", i, t.op), t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
